// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding req/ack read, PC load on accept/redirect, small FIFO towards decode.
// Optional `FETCH_MISALIGN_TRAP_EN: a misaligned PC pushes a trap marker and halts fetch until redirect.
module instruction_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic        pc_load,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ISSUE, WAIT, DROP, HALT} state_e;
`else
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_e;
`endif

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          push, pop, has_space;
  logic [31:0]   push_pc, push_instr;

  assign has_space = (count_q < CW'(FIFO_DEPTH));
  assign pop       = if_valid && if_ready;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_load    = 1'b0;
    pc_next    = mem_addr_q + 32'd4;
    push       = 1'b0;
    push_pc    = mem_addr_q;
    push_instr = mem_rdata;
    case (state_q)
      ISSUE: begin
        // pc_in is stale during a redirect cycle, so issue only once PC holds the target.
        if (!redirect_valid && has_space) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_in[1:0] != 2'b00) begin
            push       = 1'b1;
            push_pc    = pc_in;
            push_instr = 32'h0;
            state_d    = HALT;
          end else
`endif
          begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_in;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ISSUE;
          if (!redirect_valid) begin
            push    = 1'b1;
            pc_load = 1'b1;
          end
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ISSUE;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: begin
        if (redirect_valid) state_d = ISSUE;
      end
`endif
      default: state_d = ISSUE;
    endcase
    if (redirect_valid) begin
      pc_load = 1'b1;
      pc_next = redirect_target;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // A redirect empties the buffer even if decode pops the head this cycle.
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ISSUE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= BOOT_ADDRESS;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= push_pc;
      fifo_instr_q[wr_ptr_q] <= push_instr;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fifo_mis_q [FIFO_DEPTH];
  always_ff @(posedge clk) begin
    if (push) fifo_mis_q[wr_ptr_q] <= (state_q == ISSUE);
  end
  assign if_misalign = if_valid && fifo_mis_q[rd_ptr_q];
`else
  assign if_misalign = 1'b0;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_valid = (count_q != '0);
  assign if_pc    = fifo_pc_q[rd_ptr_q];
  assign if_instr = fifo_instr_q[rd_ptr_q];
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC register + memory responder + queue-based fetch-stream model.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_reg;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc, if_instr;
  logic        if_misalign;

  instruction_fetch #(.BOOT_ADDRESS(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_reg), .pc_load(pc_load), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  // Upstream PC register driven by the stage's load port.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_reg <= BOOT;
    else if (pc_load) pc_reg <= pc_next;
  end

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int          cmp_count = 0;
  int          err_count = 0;
  logic [31:0] salt;

  // Reference model: expected decode stream and where the next fetch must go.
  ent_t        fq[$];
  logic [31:0] next_fetch, out_addr;
  bit          dropped, prev_req;
  int          pushes;

  // Per-cycle observations and model predictions.
  logic        o_valid, o_mis, o_req, o_new_req, o_ack, o_load;
  logic [31:0] o_pc, o_instr, o_addr, o_next;
  logic        e_valid, e_load, e_fit;
  logic [31:0] e_pc, e_instr, e_addr, e_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ salt;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ack = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    fq.delete();
    next_fetch = BOOT; out_addr = BOOT; dropped = 1'b0; prev_req = 1'b0; pushes = 0;
    reset_n = 1'b1;
  endtask

  // One clock: sample at negedge, drive inputs, capture combinational outputs, advance model.
  task automatic step(input bit ack, input bit redir, input logic [31:0] tgt, input bit rdy);
    ent_t e;
    o_valid = if_valid; o_pc = if_pc; o_instr = if_instr; o_mis = if_misalign;
    o_req = mem_req; o_addr = mem_addr;
    o_new_req = mem_req && !prev_req;
    e_valid = (fq.size() != 0);
    e_pc    = e_valid ? fq[0].pc : 32'h0;
    e_instr = e_valid ? fq[0].instr : 32'h0;
    e_addr  = prev_req ? out_addr : next_fetch;
    e_fit   = (fq.size() + int'(mem_req)) <= DEPTH;
    mem_ack   = ack && mem_req;
    mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom;
    o_ack = mem_ack;
    redirect_valid = redir; redirect_target = tgt; if_ready = rdy;
    #1;
    o_load = pc_load; o_next = pc_next;
    e_load = 1'b0; e_next = 32'h0;
    if (redir) begin
      e_load = 1'b1; e_next = tgt;
    end else if (o_ack && !dropped) begin
      e_load = 1'b1; e_next = e_addr + 32'd4;
    end
    if (o_new_req) out_addr = next_fetch;
    if (e_valid && rdy) void'(fq.pop_front());
    if (redir) begin
      fq.delete();
      next_fetch = tgt;
      dropped = o_req && !o_ack;
    end else if (o_ack) begin
      if (!dropped) begin
        e.pc = e_addr; e.instr = mem_word(e_addr);
        fq.push_back(e);
        next_fetch = e_addr + 32'd4;
        pushes++;
      end
      dropped = 1'b0;
    end
    prev_req = o_req;
    @(negedge clk);
    mem_ack = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk); #1;
    cmp_count++; if (mem_req !== 1'b0) begin err_count++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    cmp_count++; if (mem_addr !== BOOT) begin err_count++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, BOOT); end
    cmp_count++; if (if_valid !== 1'b0) begin err_count++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    cmp_count++; if (pc_load !== 1'b0) begin err_count++; $display("FAIL reset_pc_load: got %b expected 0", pc_load); end
    do_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    int acks = 0, loads = 0;
    do_reset();
    repeat (12) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (o_new_req) addrs.push_back(o_addr);
      if (o_ack) acks++;
      if (o_load) loads++;
      cmp_count++;
      if (o_load !== e_load || (e_load && o_next !== e_next)) begin
        err_count++; $display("FAIL seq_pc_load: got %b/%h expected %b/%h", o_load, o_next, e_load, e_next);
      end
      if (e_valid) begin
        cmp_count++;
        if (o_valid !== 1'b1 || o_pc !== e_pc || o_instr !== e_instr) begin
          err_count++; $display("FAIL seq_head: got %b %h %h expected 1 %h %h", o_valid, o_pc, o_instr, e_pc, e_instr);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cmp_count++;
      if (i >= addrs.size() || addrs[i] !== 32'(4 * i)) begin
        err_count++; $display("FAIL seq_addr%0d: got %h expected %h", i, (i < addrs.size()) ? addrs[i] : 32'hx, 32'(4 * i));
      end
    end
    cmp_count++; if (acks != 6) begin err_count++; $display("FAIL seq_ack_count: got %0d expected 6", acks); end
    cmp_count++; if (loads != acks) begin err_count++; $display("FAIL seq_load_count: got %0d expected %0d", loads, acks); end
  endtask

  task automatic test_backpressure();
    int acks = 0, n = 0;
    do_reset();
    repeat (12) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (o_ack) acks++;
    end
    cmp_count++; if (acks != DEPTH) begin err_count++; $display("FAIL bp_fetches: got %0d expected %0d", acks, DEPTH); end
    cmp_count++; if (mem_req !== 1'b0) begin err_count++; $display("FAIL bp_req_idle: got %b expected 0", mem_req); end
    cmp_count++;
    if (if_valid !== 1'b1 || if_pc !== BOOT) begin
      err_count++; $display("FAIL bp_head: got %b %h expected 1 %h", if_valid, if_pc, BOOT);
    end
    do begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h8) begin
      err_count++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=00000008", o_new_req, o_addr);
    end
  endtask

  task automatic test_redirect_drop();
    int n = 0;
    do_reset();
    while (!(mem_req && mem_addr == 32'h8) && n < 20) begin step(1'b1, 1'b0, 32'h0, 1'b1); n++; end
    cmp_count++; if (n >= 20) begin err_count++; $display("FAIL drop_reach_8: got timeout expected req at 00000008"); end
    step(1'b0, 1'b1, 32'h100, 1'b1);
    cmp_count++;
    if (o_load !== 1'b1 || o_next !== 32'h100) begin
      err_count++; $display("FAIL drop_redirect_load: got %b/%h expected 1/00000100", o_load, o_next);
    end
    repeat (2) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      cmp_count++;
      if (o_req !== 1'b1 || o_addr !== 32'h8) begin
        err_count++; $display("FAIL drop_hold: got %b/%h expected 1/00000008", o_req, o_addr);
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    cmp_count++; if (o_load !== 1'b0) begin err_count++; $display("FAIL drop_ack_load: got %b expected 0", o_load); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    cmp_count++; if (o_valid !== 1'b0) begin err_count++; $display("FAIL drop_fifo_empty: got %b expected 0", o_valid); end
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h100) begin
      err_count++; $display("FAIL drop_next_addr: got req=%b addr=%h expected req=1 addr=00000100", o_new_req, o_addr);
    end
  endtask

  task automatic test_redirect_with_ack();
    int n = 0;
    do_reset();
    while (!mem_req && n < 5) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    step(1'b1, 1'b1, 32'h200, 1'b1);
    cmp_count++;
    if (o_ack !== 1'b1 || o_load !== 1'b1 || o_next !== 32'h200) begin
      err_count++; $display("FAIL rack_load: got ack=%b %b/%h expected ack=1 1/00000200", o_ack, o_load, o_next);
    end
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b1); n++;
      cmp_count++; if (o_valid !== 1'b0) begin err_count++; $display("FAIL rack_no_push: got %b expected 0", o_valid); end
    end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h200) begin
      err_count++; $display("FAIL rack_next_addr: got req=%b addr=%h expected req=1 addr=00000200", o_new_req, o_addr);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    while (!mem_req && n < 5) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'hFFFF_FFFC) begin
      err_count++; $display("FAIL wrap_req_addr: got %b/%h expected 1/fffffffc", o_new_req, o_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    cmp_count++;
    if (o_load !== 1'b1 || o_next !== 32'h0) begin
      err_count++; $display("FAIL wrap_pc_next: got %b/%h expected 1/00000000", o_load, o_next);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    cmp_count++;
    if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_instr !== mem_word(32'hFFFF_FFFC)) begin
      err_count++; $display("FAIL wrap_head: got %b %h %h expected 1 fffffffc %h", o_valid, o_pc, o_instr, mem_word(32'hFFFF_FFFC));
    end
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h0) begin
      err_count++; $display("FAIL wrap_next_req: got %b/%h expected 1/00000000", o_new_req, o_addr);
    end
  endtask

  task automatic test_misalign();
    int n = 0;
    bit saw_req = 1'b0;
    do_reset();
    while (!mem_req && n < 5) begin step(1'b0, 1'b0, 32'h0, 1'b0); n++; end
    step(1'b1, 1'b1, 32'h102, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (8) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (o_req) saw_req = 1'b1;
    end
    cmp_count++; if (saw_req) begin err_count++; $display("FAIL mis_no_req: got req=1 expected 0"); end
    cmp_count++;
    if (if_valid !== 1'b1 || if_misalign !== 1'b1 || if_pc !== 32'h102 || if_instr !== 32'h0) begin
      err_count++; $display("FAIL mis_marker: got %b %b %h %h expected 1 1 00000102 00000000", if_valid, if_misalign, if_pc, if_instr);
    end
    step(1'b0, 1'b1, 32'h200, 1'b0);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b0); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h200) begin
      err_count++; $display("FAIL mis_resume: got %b/%h expected 1/00000200", o_new_req, o_addr);
    end
`else
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0, 1'b0); n++; end while (!o_new_req && n < 10);
    cmp_count++;
    if (!o_new_req || o_addr !== 32'h102) begin
      err_count++; $display("FAIL mis_fetch_addr: got %b/%h expected 1/00000102", o_new_req, o_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    if (saw_req) n = 0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    cmp_count++;
    if (o_valid !== 1'b1 || o_mis !== 1'b0 || o_pc !== 32'h102 || o_instr !== mem_word(32'h102)) begin
      err_count++; $display("FAIL mis_plain_entry: got %b %b %h %h expected 1 0 00000102 %h", o_valid, o_mis, o_pc, o_instr, mem_word(32'h102));
    end
`endif
  endtask

  task automatic test_reset_mid_request();
    int n = 0;
    do_reset();
    while (!mem_req && n < 5) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    reset_n = 1'b0;
    #1;
    cmp_count++;
    if (mem_req !== 1'b0 || mem_addr !== BOOT) begin
      err_count++; $display("FAIL midreset: got %b/%h expected 0/%h", mem_req, mem_addr, BOOT);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit ack, redir, rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ack   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rdy   = ($urandom_range(0, 9) < 6);
      tgt   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step(ack, redir, tgt, rdy);
      cmp_count++;
      if (o_valid !== e_valid) begin err_count++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, o_valid, e_valid); end
      if (e_valid) begin
        cmp_count++;
        if (o_pc !== e_pc || o_instr !== e_instr || o_mis !== 1'b0) begin
          err_count++; $display("FAIL rnd_head c=%0d: got %h %h %b expected %h %h 0", c, o_pc, o_instr, o_mis, e_pc, e_instr);
        end
      end
      if (o_req) begin
        cmp_count++;
        if (o_addr !== e_addr) begin err_count++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, o_addr, e_addr); end
        cmp_count++;
        if (!e_fit) begin err_count++; $display("FAIL rnd_space c=%0d: got req with %0d entries expected room", c, fq.size()); end
      end
      cmp_count++;
      if (o_load !== e_load || (e_load && o_next !== e_next)) begin
        err_count++; $display("FAIL rnd_pc_load c=%0d: got %b/%h expected %b/%h", c, o_load, o_next, e_load, e_next);
      end
    end
    cmp_count++;
    if (pushes < 40) begin err_count++; $display("FAIL rnd_progress: got %0d pushes expected at least 40", pushes); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    salt = $urandom;
    next_fetch = BOOT; out_addr = BOOT; dropped = 1'b0; prev_req = 1'b0; pushes = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_with_ack();
    test_wrap();
    test_misalign();
    test_reset_mid_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
